// File: rtl/dma_pkg.sv
// Shared constants for the ramDmaCi DMA path: widths, FSM encodings, direction and status bits.
package dma_pkg;

    localparam int BUS_WIDTH = 32;
    localparam int MEM_AW    = 9;
    localparam int BLK_W     = 10;
    localparam int BURST_W   = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_REQUEST   = 3'd1;
    localparam logic [2:0] ST_INIT      = 3'd2;
    localparam logic [2:0] ST_READ      = 3'd3;
    localparam logic [2:0] ST_WRITE     = 3'd4;
    localparam logic [2:0] ST_END_WRITE = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;
    localparam logic [2:0] ST_ERROR     = 3'd7;

    localparam logic DIR_BUS_TO_MEM = 1'b0;
    localparam logic DIR_MEM_TO_BUS = 1'b1;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_ERROR_BIT = 1;

    // Words in the next burst: the configured burst length, clipped to what is left.
    function automatic logic [BLK_W-1:0] burst_word_count(input logic [BLK_W-1:0]   remaining,
                                                          input logic [BURST_W-1:0] burst_size);
        logic [BLK_W-1:0] full;
        full = BLK_W'(burst_size) + BLK_W'(1);
        return (remaining < full) ? remaining : full;
    endfunction

endpackage

// File: rtl/dma_burst_controller.sv
// Purpose: bus-master sequencer moving a block of words between the bus and SSRAM in bursts.
// Latency: requestBus the cycle after startDma; INIT the cycle after grant; one word per cycle.
// Backpressure: write words hold while busyIn is high; read words follow the slave's dataValidIn.
module dma_burst_controller
    import dma_pkg::*;
(
    input  logic                   clock,
    input  logic                   nReset,
    input  logic                   startDma,
    input  logic                   direction,
    input  logic [BUS_WIDTH-1:0]   busStartAddress,
    input  logic [MEM_AW-1:0]      memStartAddress,
    input  logic [BLK_W-1:0]       blockSize,
    input  logic [BURST_W-1:0]     burstSize,
    output logic                   dmaBusy,
    output logic                   dmaError,
    output logic                   requestBus,
    input  logic                   busGrant,
    output logic                   beginTransactionOut,
    output logic                   endTransactionOut,
    output logic                   dataValidOut,
    output logic                   readNotWriteOut,
    output logic [BUS_WIDTH-1:0]   addressDataOut,
    output logic [BUS_WIDTH/8-1:0] byteEnablesOut,
    output logic [BURST_W-1:0]     burstSizeOut,
    input  logic [BUS_WIDTH-1:0]   addressDataIn,
    input  logic                   dataValidIn,
    input  logic                   endTransactionIn,
    input  logic                   busyIn,
    input  logic                   errorIn,
    output logic [MEM_AW-1:0]      memAddress,
    output logic                   memWriteEnable,
    output logic [BUS_WIDTH-1:0]   memWriteData,
    input  logic [BUS_WIDTH-1:0]   memReadData
);

    logic [2:0]           state_q, state_d;
    logic                 dir_q, dir_d;
    logic [BUS_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [MEM_AW-1:0]    mem_addr_q, mem_addr_d;
    logic [BLK_W-1:0]     remaining_q, remaining_d, remaining_dec;
    logic [BURST_W-1:0]   burst_cfg_q, burst_cfg_d;
    logic [BLK_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [BLK_W-1:0]     burst_words;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;
    logic                 word_done;

    assign burst_words   = burst_word_count(remaining_q, burst_cfg_q);
    assign remaining_dec = (remaining_q != '0) ? remaining_q - BLK_W'(1) : '0;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        bus_addr_d  = bus_addr_q;
        mem_addr_d  = mem_addr_q;
        remaining_d = remaining_q;
        burst_cfg_d = burst_cfg_q;
        beat_cnt_d  = beat_cnt_q;
        busy_d      = busy_q;
        error_d     = error_q;
        word_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (startDma && (blockSize != '0)) begin
                    state_d     = ST_REQUEST;
                    dir_d       = direction;
                    bus_addr_d  = busStartAddress & ~BUS_WIDTH'(3);
                    mem_addr_d  = memStartAddress;
                    remaining_d = blockSize;
                    burst_cfg_d = burstSize;
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                end
            end
            ST_REQUEST: begin
                if (busGrant) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (errorIn) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end else begin
                    beat_cnt_d = burst_words;
                    state_d    = (dir_q == DIR_MEM_TO_BUS) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (errorIn) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end else begin
                    word_done = dataValidIn;
                    // A word arriving with the end strobe still counts before the end is judged.
                    if (endTransactionIn)
                        state_d = (((dataValidIn) ? remaining_dec : remaining_q) == '0) ? ST_DONE : ST_REQUEST;
                end
            end
            ST_WRITE: begin
                if (errorIn) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end else if (!busyIn) begin
                    word_done = 1'b1;
                    if (beat_cnt_q == BLK_W'(1)) state_d = ST_END_WRITE;
                end
            end
            ST_END_WRITE: state_d = (remaining_q == '0) ? ST_DONE : ST_REQUEST;
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (word_done) begin
            bus_addr_d  = bus_addr_q + BUS_WIDTH'(4);
            mem_addr_d  = mem_addr_q + MEM_AW'(1);
            remaining_d = remaining_dec;
            beat_cnt_d  = beat_cnt_q - BLK_W'(1);
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            bus_addr_q  <= '0;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            burst_cfg_q <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            bus_addr_q  <= bus_addr_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            burst_cfg_q <= burst_cfg_d;
            beat_cnt_q  <= beat_cnt_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign dmaBusy             = busy_q;
    assign dmaError            = error_q;
    assign requestBus          = (state_q == ST_REQUEST);
    assign beginTransactionOut = (state_q == ST_INIT);
    assign endTransactionOut   = (state_q == ST_END_WRITE) || (state_q == ST_ERROR);
    assign dataValidOut        = (state_q == ST_WRITE);
    assign readNotWriteOut     = (state_q == ST_INIT) && (dir_q == DIR_BUS_TO_MEM);
    assign byteEnablesOut      = (state_q == ST_INIT) ? '1 : '0;
    assign burstSizeOut        = (state_q == ST_INIT) ? BURST_W'(burst_words - BLK_W'(1)) : '0;
    assign addressDataOut      = (state_q == ST_INIT)  ? bus_addr_q :
                                 (state_q == ST_WRITE) ? memReadData : '0;

    // SSRAM reads take a cycle, so prefetch the next word whenever the current one is taken.
    assign memAddress     = ((state_q == ST_WRITE) && !busyIn) ? mem_addr_q + MEM_AW'(1) : mem_addr_q;
    assign memWriteEnable = (state_q == ST_READ) && dataValidIn;
    assign memWriteData   = (state_q == ST_READ) ? addressDataIn : '0;

endmodule

// File: tb/tb_dma_burst_controller.sv
// Directed bench for dma_burst_controller with a behavioural SSRAM and bus slave.
module tb_dma_burst_controller;
    import dma_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nReset, startDma, direction, busGrant;
    logic [31:0] busStartAddress, addressDataIn, memReadData, addressDataOut, memWriteData;
    logic [8:0]  memStartAddress, memAddress;
    logic [9:0]  blockSize;
    logic [7:0]  burstSize, burstSizeOut;
    logic [3:0]  byteEnablesOut;
    logic        dmaBusy, dmaError, requestBus, beginTransactionOut, endTransactionOut;
    logic        dataValidOut, readNotWriteOut, dataValidIn, endTransactionIn, busyIn, errorIn;
    logic        memWriteEnable;

    dma_burst_controller dut (
        .clock(clk), .nReset(nReset), .startDma(startDma), .direction(direction),
        .busStartAddress(busStartAddress), .memStartAddress(memStartAddress),
        .blockSize(blockSize), .burstSize(burstSize), .dmaBusy(dmaBusy), .dmaError(dmaError),
        .requestBus(requestBus), .busGrant(busGrant), .beginTransactionOut(beginTransactionOut),
        .endTransactionOut(endTransactionOut), .dataValidOut(dataValidOut),
        .readNotWriteOut(readNotWriteOut), .addressDataOut(addressDataOut),
        .byteEnablesOut(byteEnablesOut), .burstSizeOut(burstSizeOut),
        .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
        .endTransactionIn(endTransactionIn), .busyIn(busyIn), .errorIn(errorIn),
        .memAddress(memAddress), .memWriteEnable(memWriteEnable),
        .memWriteData(memWriteData), .memReadData(memReadData)
    );

    logic [31:0] mem [0:511];
    logic        tb_we;
    logic [8:0]  tb_waddr;
    logic [31:0] tb_wdata;
    logic [31:0] wexp [0:31];

    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wdata;
        else if (memWriteEnable) mem[memAddress] <= memWriteData;
        memReadData <= mem[memAddress];
    end

    int checks = 0;
    int errors = 0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        logic [92:0] v;
        v = {dmaBusy, dmaError, requestBus, beginTransactionOut, endTransactionOut, dataValidOut,
             readNotWriteOut, addressDataOut, byteEnablesOut, burstSizeOut, memAddress,
             memWriteEnable, memWriteData};
        checks++;
        assert (v === '0) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=0", tag, v);
        end
    endtask

    task automatic poke(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic start(input logic dir, input logic [31:0] ba, input logic [8:0] ma,
                         input logic [9:0] bs, input logic [7:0] bz);
        @(negedge clk);
        direction = dir; busStartAddress = ba; memStartAddress = ma;
        blockSize = bs; burstSize = bz; startDma = 1'b1;
        @(negedge clk);
        startDma = 1'b0;
        busStartAddress = 32'hDEAD_BEE0; memStartAddress = 9'd5;
        blockSize = 10'd3; burstSize = 8'd1; direction = ~dir;
        #1;
    endtask

    task automatic wait_request(input string tag);
        int n = 0;
        while (requestBus !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check1({tag, "_req"}, requestBus, 1'b1);
    endtask

    task automatic grant_init(input string tag, input logic [31:0] exp_addr,
                              input logic [7:0] exp_bsz, input logic exp_rnw);
        busGrant = 1'b1;
        @(negedge clk);
        busGrant = 1'b0;
        #1;
        check1({tag, "_begin"}, beginTransactionOut, 1'b1);
        check1({tag, "_req_drop"}, requestBus, 1'b0);
        check32({tag, "_addr"}, addressDataOut, exp_addr);
        check32({tag, "_bsz"}, 32'(burstSizeOut), 32'(exp_bsz));
        check1({tag, "_rnw"}, readNotWriteOut, exp_rnw);
        check32({tag, "_be"}, 32'(byteEnablesOut), 32'hF);
    endtask

    task automatic read_burst(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dataValidIn = 1'b1;
            addressDataIn = base + 32'(i);
            endTransactionIn = (i == n - 1);
        end
        @(negedge clk);
        dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0;
        #1;
    endtask

    task automatic write_burst(input string tag, input int first, input int n,
                               input int busy_word, input int busy_len);
        int   got = 0;
        int   bad = 0;
        int   left = busy_len;
        logic ended = 1'b0;
        for (int c = 0; c < 40 && !ended; c++) begin
            @(negedge clk);
            busyIn = (got == busy_word) && (left > 0);
            if (busyIn) left--;
            #1;
            if (endTransactionOut) ended = 1'b1;
            else if (dataValidOut) begin
                if (got >= n || addressDataOut !== wexp[5'(first + got)]) bad++;
                if (!busyIn) got++;
            end
        end
        busyIn = 1'b0;
        check1({tag, "_end"}, ended, 1'b1);
        check32({tag, "_count"}, got, n);
        check32({tag, "_data"}, bad, 0);
    endtask

    initial begin
        logic [31:0] last_init;
        int          bad;

        nReset = 1'b0; startDma = 1'b0; direction = 1'b0; busGrant = 1'b0;
        busStartAddress = '0; memStartAddress = '0; blockSize = '0; burstSize = '0;
        addressDataIn = '0; dataValidIn = 1'b0; endTransactionIn = 1'b0;
        busyIn = 1'b0; errorIn = 1'b0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        last_init = '0;

        @(negedge clk); #1;
        check_zero("reset_outputs");
        nReset = 1'b1;

        // Read: 100 words in bursts of 10 from 0x1000 into SSRAM 220..319
        start(1'b0, 32'h0000_1000, 9'd220, 10'd100, 8'd9);
        check1("rd_busy_after_start", dmaBusy, 1'b1);
        check1("rd_req_after_start", requestBus, 1'b1);
        for (int b = 0; b < 10; b++) begin
            wait_request("rd");
            grant_init("rd", 32'h0000_1000 + 32'(40 * b), 8'd9, 1'b1);
            last_init = addressDataOut;
            read_burst(10, 32'hC0DE_0000 + 32'(b * 10));
        end
        check1("rd_busy_in_done", dmaBusy, 1'b1);
        @(negedge clk); #1;
        check1("rd_busy_cleared", dmaBusy, 1'b0);
        check32("rd_last_bus_addr", last_init + 32'd36, 32'h0000_118C);
        bad = 0;
        for (int k = 0; k < 100; k++)
            if (mem[9'(220 + k)] !== 32'hC0DE_0000 + 32'(k)) bad++;
        check32("rd_mem_contents", bad, 0);

        // Write: 5 words from SSRAM 510 wrapping to 2, busyIn stalls word 2 for 3 cycles
        wexp[0] = 32'h1111_0510; wexp[1] = 32'h2222_0511; wexp[2] = 32'h3333_0000;
        wexp[3] = 32'h4444_0001; wexp[4] = 32'h5555_0002;
        poke(9'd510, wexp[0]); poke(9'd511, wexp[1]); poke(9'd0, wexp[2]);
        poke(9'd1, wexp[3]);   poke(9'd2, wexp[4]);
        start(1'b1, 32'h0000_2000, 9'd510, 10'd5, 8'd7);
        wait_request("wr");
        grant_init("wr", 32'h0000_2000, 8'd4, 1'b0);
        check32("wr_init_mem_addr", 32'(memAddress), 32'd510);
        write_burst("wr", 0, 5, 2, 3);
        @(negedge clk); #1;
        check1("wr_busy_in_done", dmaBusy, 1'b1);
        @(negedge clk); #1;
        check1("wr_busy_cleared", dmaBusy, 1'b0);

        // Ignored starts: zero block size in IDLE, and any start while busy
        @(negedge clk);
        blockSize = 10'd0; startDma = 1'b1;
        @(negedge clk);
        startDma = 1'b0;
        #1;
        check1("zero_blk_busy", dmaBusy, 1'b0);
        check1("zero_blk_req", requestBus, 1'b0);
        @(negedge clk); #1;
        check1("zero_blk_req_later", requestBus, 1'b0);

        start(1'b0, 32'h0000_4000, 9'd100, 10'd1, 8'd0);
        @(negedge clk);
        direction = 1'b1; busStartAddress = 32'h0000_5000; blockSize = 10'd7; startDma = 1'b1;
        @(negedge clk);
        startDma = 1'b0;
        #1;
        check1("busy_start_req", requestBus, 1'b1);
        grant_init("busy", 32'h0000_4000, 8'd0, 1'b1);
        read_burst(1, 32'h7700_00AA);
        check1("busy_busy_in_done", dmaBusy, 1'b1);
        @(negedge clk); #1;
        check1("busy_busy_cleared", dmaBusy, 1'b0);
        check32("busy_mem", mem[9'd100], 32'h7700_00AA);

        // Error on the third word of a read
        start(1'b0, 32'h0000_3000, 9'd40, 10'd8, 8'd7);
        wait_request("err");
        grant_init("err", 32'h0000_3000, 8'd7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dataValidIn = 1'b1; addressDataIn = 32'hE000_0000 + 32'(i); errorIn = (i == 2);
        end
        @(negedge clk);
        dataValidIn = 1'b0; errorIn = 1'b0; addressDataIn = '0;
        #1;
        check1("err_end_strobe", endTransactionOut, 1'b1);
        check1("err_flag_set", dmaError, 1'b1);
        @(negedge clk); #1;
        check1("err_busy_cleared", dmaBusy, 1'b0);
        check1("err_flag_sticky", dmaError, 1'b1);
        check1("err_end_dropped", endTransactionOut, 1'b0);
        check32("err_mem_w1", mem[9'd41], 32'hE000_0001);

        // Next start clears the error; reset mid-burst
        start(1'b0, 32'h0000_6000, 9'd300, 10'd4, 8'd3);
        check1("rst_err_cleared", dmaError, 1'b0);
        wait_request("rst");
        grant_init("rst", 32'h0000_6000, 8'd3, 1'b1);
        @(negedge clk);
        dataValidIn = 1'b1; addressDataIn = 32'h0BAD_0000;
        #1;
        check1("rst_mem_we", memWriteEnable, 1'b1);
        nReset = 1'b0;
        #1;
        check_zero("rst_outputs_mid_burst");
        @(negedge clk);
        dataValidIn = 1'b0; addressDataIn = '0; nReset = 1'b1;
        #1;
        check_zero("rst_outputs_after_release");

        // Post-reset write of 2 words with single-word bursts
        wexp[8] = 32'hA5A5_0300; wexp[9] = 32'h5A5A_0301;
        poke(9'd300, wexp[8]); poke(9'd301, wexp[9]);
        start(1'b1, 32'h0000_7000, 9'd300, 10'd2, 8'd0);
        for (int b = 0; b < 2; b++) begin
            wait_request("post");
            grant_init("post", 32'h0000_7000 + 32'(4 * b), 8'd0, 1'b0);
            write_burst("post", 8 + b, 1, -1, 0);
        end
        @(negedge clk); #1;
        check1("post_busy_in_done", dmaBusy, 1'b1);
        @(negedge clk); #1;
        check1("post_busy_cleared", dmaBusy, 1'b0);
        check1("post_error_clear", dmaError, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_burst_controller.md
# dma_burst_controller

Sequencing engine behind the DMA registers of the `ramDmaCi` custom instruction. On a start command it moves a block of 32-bit words between the bus and the 512-word SSRAM as a series of bus bursts: it arbitrates for the bus, issues bursts, tracks remaining words and addresses, and reports busy/error back to the status register. The register file and the CPU read/write path stay in `ramDmaCi`; this block owns only the bus-master side and the SSRAM port used by DMA.

## Interface
- `BUS_WIDTH`, 32, bus data/address width.
- `MEM_AW`, 9, SSRAM word-address width (512 words).
- `clock`  in  1  system clock, all logic on rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `startDma`  in  1  one-cycle pulse: control-register write with bit0=1.
- `direction`  in  1  control bit1: 0 = bus→SSRAM (read), 1 = SSRAM→bus (write).
- `busStartAddress`  in  32  byte address; bits[1:0] ignored.
- `memStartAddress`  in  9  first SSRAM word.
- `blockSize`  in  10  words to transfer.
- `burstSize`  in  8  words per burst minus 1.
- `dmaBusy`  out  1  status bit0.
- `dmaError`  out  1  status bit1, sticky.
- `requestBus` out 1 / `busGrant` in 1  bus arbitration.
- `beginTransactionOut`, `endTransactionOut`, `dataValidOut`, `readNotWriteOut`  out  1  bus control.
- `addressDataOut`  out  32;  `byteEnablesOut`  out  4;  `burstSizeOut`  out  8.
- `addressDataIn`  in  32;  `dataValidIn`, `endTransactionIn`, `busyIn`, `errorIn`  in  1.
- `memAddress`  out  9;  `memWriteEnable`  out  1;  `memWriteData`  out  32;  `memReadData`  in  32 (valid one cycle after `memAddress`).

## Operation
- States: IDLE, REQUEST, INIT, READ, WRITE, END_WRITE, DONE, ERROR.
- IDLE: `startDma` with `blockSize`≠0 latches all configuration inputs, clears `dmaError`, and enters REQUEST. `startDma` with `blockSize`=0 is ignored. `startDma` outside IDLE is ignored. Input changes mid-transfer have no effect.
- REQUEST: assert `requestBus`. When `busGrant` is sampled high, go to INIT.
- INIT (one cycle): `beginTransactionOut`=1; `addressDataOut`=current bus address; `burstSizeOut`=min(remaining, `burstSize`+1)−1; `readNotWriteOut`=~direction; `byteEnablesOut`=4'hF; `requestBus` drops. Next state is READ (direction 0) or WRITE (direction 1).
- READ: each `dataValidIn` writes `addressDataIn` to SSRAM at the current memory address. The memory address and bus address advance, and remaining decrements. On `endTransactionIn`: if remaining=0 go to DONE, else go to REQUEST.
- WRITE: drive `dataValidOut`=1 with the SSRAM word. A word is consumed when `busyIn`=0. While `busyIn`=1, data and addresses hold. No word is skipped or duplicated. After the last word of the burst is consumed, go to END_WRITE.
- END_WRITE (one cycle): `endTransactionOut`=1. Then go to DONE if remaining=0, else REQUEST.
- DONE (one cycle): drop busy, then go to IDLE.
- `errorIn` in READ, WRITE or INIT: go to ERROR. ERROR sets `dmaError`, asserts `endTransactionOut` for one cycle, then goes to IDLE.
- Arithmetic:
  - Bus address += 4 per word, wrapping modulo 2^32.
  - Memory address += 1 per word, wrapping 511→0.
  - Remaining is 10 bits.

## Timing
- Reset (asynchronous, any state): go to IDLE. All outputs are 0 and all counters are 0, including `dmaError`.
- `startDma` sampled at edge N: `dmaBusy`=1 and `requestBus`=1 after edge N.
- Grant sampled at edge M: INIT occupies cycle M..M+1.
- READ: `memWriteEnable` is asserted in the same cycle as `dataValidIn` (combinational).
- WRITE: `memAddress` for word k+1 is presented while word k is on the bus, so back-to-back words need no bubble when `busyIn`=0.
- `dmaBusy` falls on the edge leaving DONE. Minimum transfer: 1 word, 5 cycles after grant.
- `endTransactionIn` together with `dataValidIn` in the same cycle: the word is written, then the end is processed.
- `errorIn` together with `endTransactionIn`: error takes precedence.

## Structure
- `dma_pkg`: state enum, `BUS_WIDTH`, `MEM_AW`, direction encodings, status bit indices. `ramDmaCi` also uses this package.
- No sub-module. A single FSM plus counters; target 200–300 lines.

## Test plan
- Read, blockSize=100, burstSize=9, busStart=0x1000, memStart=220: 10 bursts of 10 words each. SSRAM[220..319] equal the bus data. Last bus address is 0x118C. `dmaBusy` is 0 afterwards.
- Write, blockSize=5, burstSize=7, memStart=510: one burst with `burstSizeOut`=4. Memory addresses go 510, 511, 0, 1, 2. `busyIn` held high for 3 cycles on word 2 → bus receives exactly 5 words in order.
- `startDma` while busy, and `startDma` with blockSize=0: no state change, no `requestBus`.
- `errorIn` during the 3rd word of a read → `dmaError`=1 and `dmaBusy`=0. The next start clears `dmaError`.
- `nReset` low mid-burst → all outputs 0 immediately. After release, the FSM is in IDLE and a new transfer completes normally.
